// File: rtl/aes_key_schedule.sv
// AES-128/192/256 key-schedule engine: one schedule word per clock into a
// round-key store; round keys are read back 128 bits at a time, registered.
module aes_key_schedule #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [0:KEY_BITS-1] key,
  output logic                busy,
  output logic                done,
  output logic                key_ready,
  input  logic                rd_en,
  input  logic [3:0]          rd_round,
  output logic [0:127]        rd_key,
  output logic                rd_valid,
  output logic                rd_err
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int TW = 4 * (NR + 1);

  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic {
    S_IDLE,
    S_EXPAND
  } state_t;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] v;
    case (idx)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  state_t       r_state;
  state_t       w_state_nxt;
  logic         w_start_acc;
  logic         w_last;

  logic [31:0]  r_store [TW];
  // r_win[0] is w[i-Nk], r_win[NK-1] is w[i-1]
  logic [31:0]  r_win [NK];
  logic [5:0]   r_idx;
  logic [2:0]   r_mod;
  logic [3:0]   r_rcon_idx;

  logic         r_done;
  logic         r_key_ready;
  logic         r_rd_valid;
  logic         r_rd_err;
  logic [0:127] r_rd_key;

  logic [31:0]  w_prev;
  logic [31:0]  w_sub_in;
  logic [31:0]  w_sub;
  logic [31:0]  w_temp;
  logic [31:0]  w_new;
  logic         w_mod0;
  logic         w_mod4;
  logic         w_rd_ok;

  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_start_acc = 1'b1;
          w_state_nxt = S_EXPAND;
        end
      end
      S_EXPAND: begin
        if (r_idx == 6'(TW - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_prev   = r_win[NK-1];
    w_mod0   = (r_mod == 3'd0);
    w_mod4   = (NK == 8) && (r_mod == 3'd4);
    w_sub_in = w_mod0 ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    w_sub    = sub_word(w_sub_in);
    if (w_mod0) begin
      w_temp = w_sub ^ {rcon(r_rcon_idx), 24'h000000};
    end else if (w_mod4) begin
      w_temp = w_sub;
    end else begin
      w_temp = w_prev;
    end
    w_new = r_win[0] ^ w_temp;
  end

  // i mod Nk is a wrap counter; the Rcon index steps as it wraps back to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= '0;
      r_mod       <= '0;
      r_rcon_idx  <= '0;
      r_done      <= 1'b0;
      r_key_ready <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_start_acc) begin
        r_idx       <= 6'(NK);
        r_mod       <= '0;
        r_rcon_idx  <= 4'd1;
        r_key_ready <= 1'b0;
      end else if (r_state == S_EXPAND) begin
        r_idx <= r_idx + 6'd1;
        if (r_mod == 3'(NK - 1)) begin
          r_mod      <= '0;
          r_rcon_idx <= r_rcon_idx + 4'd1;
        end else begin
          r_mod <= r_mod + 3'd1;
        end
        if (w_last) begin
          r_key_ready <= 1'b1;
        end
      end
    end
  end

  // Store and window carry no reset: key_ready=0 gates every read.
  always_ff @(posedge clk) begin
    if (w_start_acc) begin
      for (int unsigned j = 0; j < NK; j++) begin
        r_store[j] <= key[32*j +: 32];
        r_win[j]   <= key[32*j +: 32];
      end
    end else if (r_state == S_EXPAND) begin
      r_store[r_idx] <= w_new;
      for (int unsigned j = 0; j + 1 < NK; j++) begin
        r_win[j] <= r_win[j+1];
      end
      r_win[NK-1] <= w_new;
    end
  end

  assign w_rd_ok = rd_en && r_key_ready && (rd_round <= 4'(NR));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
      r_rd_key   <= '0;
    end else begin
      r_rd_valid <= w_rd_ok;
      r_rd_err   <= rd_en && !w_rd_ok;
      if (w_rd_ok) begin
        r_rd_key <= {r_store[{rd_round, 2'b00}], r_store[{rd_round, 2'b01}],
                     r_store[{rd_round, 2'b10}], r_store[{rd_round, 2'b11}]};
      end
    end
  end

  assign busy      = (r_state == S_EXPAND);
  assign done      = r_done;
  assign key_ready = r_key_ready;
  assign rd_key    = r_rd_key;
  assign rd_valid  = r_rd_valid;
  assign rd_err    = r_rd_err;

endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Sequential, parametrised AES key-schedule engine supporting AES-128/192/256. It accepts a cipher key with a start handshake and generates one 32-bit schedule word per clock into an internal round-key store. Once generation is complete, the cipher datapath reads any round key through a registered read port. It replaces per-round combinational expansion in the cipher core with a single precomputed store, shared by encryption and decryption round sequencing.

## Interface
- KEY_BITS, 128, cipher key length; legal values 128, 192, 256; derived Nk = KEY_BITS/32, Nr = Nk+6, TW = 4*(Nr+1) words (44/52/60)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; **synchronous, active-high**, one clock domain only
- start  in  1  request expansion of key; sampled only when busy=0
- key  in  [0:KEY_BITS-1]  cipher key; key[0:31] is w[0] (FIPS-197 byte order, byte 0 at bit 0); sampled only in the start-accept cycle
- busy  out  1  expansion in progress
- done  out  1  one-cycle pulse on the cycle the last word is committed
- key_ready  out  1  store holds a complete, valid schedule
- rd_en  in  1  round-key read request
- rd_round  in  [3:0]  round index 0..Nr
- rd_key  out  [0:127]  round key w[4r..4r+3], w[4r] at bits [0:31]
- rd_valid  out  1  rd_key valid, one cycle after rd_en
- rd_err  out  1  one-cycle pulse: read rejected (key_ready=0 or rd_round>Nr)

## Operation
- FSM states: IDLE, EXPAND.
- IDLE: start=1 loads w[0..Nk-1] from key into the store and into an Nk-word sliding window; sets index i=Nk; clears key_ready; goes to EXPAND.
- EXPAND, one word per cycle: temp=w[i-1].
  - If i mod Nk==0: temp = SubWord(RotWord(temp)) ^ {Rcon[i/Nk],24'h0}.
  - Else if Nk==8 and i mod 8==4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp.
  - w[i-Nk] and w[i-1] come from the window registers, never from a store read.
- Rcon sequence: 01,02,04,08,10,20,40,80,1B,36. Max index used: 10/8/7 for 128/192/256.
- i mod Nk is tracked by a wrap counter, not a divider. The Rcon index increments on each wrap.
- After writing w[TW-1]: done=1, key_ready=1, next state IDLE.
- S-box is the standard AES forward S-box, 4 parallel combinational lookups.
- Read: when rd_en=1, key_ready=1 and rd_round<=Nr, the next cycle has rd_key = store words 4r..4r+3 and rd_valid=1. Otherwise the next cycle has rd_valid=0, rd_err=1, and rd_key holds its previous value.
- Reads during EXPAND are rejected, since key_ready=0.
- start while busy=1: ignored, no effect on the current expansion.
- start and rd_en in the same IDLE cycle, with key_ready=1: the read is served from the old schedule (old store contents, pre-edge key_ready). The new expansion begins on the same edge.
- start with key_ready=1: the schedule is regenerated and the old keys become unreadable from the next cycle.
- rst at any point, including mid-EXPAND: the next state is IDLE and the partial schedule is discarded. Store contents need no clearing because key_ready=0 gates all reads.

## Timing
- Reset values: busy=0, done=0, key_ready=0, rd_valid=0, rd_err=0, rd_key=0, state=IDLE.
- Start accepted at edge 0: busy=1 from cycle 1.
- Expansion takes TW-Nk cycles (40/46/52). done and key_ready rise on the edge committing w[TW-1]. busy falls on that same edge.
- Start-to-done latency: TW-Nk+1 cycles (41/47/53).
- A new start is accepted on the cycle done=1 (busy=0).
- Read latency is 1 cycle, fully pipelined: back-to-back rd_en gives back-to-back rd_valid.
- Single clock, no combinational path from inputs to outputs.

## Test plan
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, start → done after 41 cycles. rd_round=0 returns the key. rd_round=10 returns d014f9a8c9ee2589e13f0cc8b6630ca6 with rd_valid one cycle after rd_en.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → done after 47 cycles. rd_round=12 returns e98ba06f448c773c8ecc720401002202. rd_round=13 gives rd_err=1, rd_valid=0.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → done after 53 cycles. rd_round=14 returns fe4890d1e6188d0b046df344706c631e.
- Read during EXPAND gives rd_err=1. A second start mid-EXPAND is ignored: done timing and final keys match the first key.
- rst asserted at cycle 20 of EXPAND → next cycle all outputs at reset values. A fresh AES-128 start then yields the correct round-10 key.
- After completion, start and rd_en(round 10) in the same cycle → rd_key = old round-10 key with rd_valid=1. key_ready=0 the following cycle. The new schedule completes 41 cycles later.
